// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_t   : controller states (RUN, LDSTALL, FLUSH, MEMWAIT)
//   REG_IDX_W : width of an architectural register index
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
// Ports:
//   id_ex_mem_rd : instruction in EX is a load
//   id_ex_rd     : destination register of the instruction in EX
//   if_id_rs1/2  : source registers of the instruction in ID
//   load_use     : 1 when ID consumes a register the EX load has not produced yet
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 id_ex_mem_rd,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic [REG_IDX_W-1:0] if_id_rs1,
  input  logic [REG_IDX_W-1:0] if_id_rs2,
  output logic                 load_use
);

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = id_ex_mem_rd && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush controller for a 5-stage in-order pipeline.
// Outputs are Mealy: decoded from the current state and current inputs.
// Priority: data-memory stall > taken branch flush > load-use stall > normal.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   id_ex_mem_rd/rd     : load flag and destination register in ID/EX
//   if_id_rs1/rs2       : source registers in IF/ID
//   ex_br_taken         : branch/jump taken, resolved in EX
//   mem_req, mem_ready  : data-memory access in MEM and its completion
//   pc_en, if_id_en,
//   ex_mem_en           : register advance enables
//   if_id_flush         : load a NOP into IF/ID
//   id_ex_sel           : 1 = pass decoded control into ID/EX, 0 = bubble
//   mem_timeout         : sticky memory-wait timeout flag
// Build option:
//   PIPE_STALL_PERF_EN  : adds 32-bit stall_cnt / flush_cnt performance counters
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_ex_mem_rd,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic [REG_IDX_W-1:0] if_id_rs1,
  input  logic [REG_IDX_W-1:0] if_id_rs2,
  input  logic                 ex_br_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 ex_mem_en,
  output logic                 if_id_flush,
  output logic                 id_ex_sel,
  output logic                 mem_timeout
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_PRE = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_flag;
  logic             load_use;
  logic             mem_stall;

  hazard_detect u_hazard_detect (
    .id_ex_mem_rd (id_ex_mem_rd),
    .id_ex_rd     (id_ex_rd),
    .if_id_rs1    (if_id_rs1),
    .if_id_rs2    (if_id_rs2),
    .load_use     (load_use)
  );

  assign mem_stall   = mem_req && !mem_ready;
  assign mem_timeout = timeout_flag;

  // Output decode and next state. rst forces the enables low combinationally
  // so a reset landing between clock edges freezes the pipeline at once.
  // Load-use is only acted on from RUN: after a load-use bubble the hazard is
  // resolved, after a flush the ID instruction is a NOP, and on memory release
  // the hazard is re-examined on the following cycle.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_sel   = 1'b1;
    state_nxt   = RUN;
    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      id_ex_sel = 1'b0;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      state_nxt = MEMWAIT;
    end else if (ex_br_taken) begin
      if_id_flush = 1'b1;
      id_ex_sel   = 1'b0;
      state_nxt   = FLUSH;
    end else if (load_use && (state == RUN)) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_sel = 1'b0;
      state_nxt = LDSTALL;
    end
  end

  // State, memory-wait counter and sticky timeout flag. The counter counts
  // every consecutive stalled cycle (including the one that enters MEMWAIT)
  // and saturates at MEM_TIMEOUT; the flag rises on the edge it gets there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_stall) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        if (wait_cnt == WAIT_PRE) begin
          timeout_flag <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef PIPE_STALL_PERF_EN
  // Free-running performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (if_id_flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_ex_mem_rd;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       ex_br_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_sel, mem_timeout;
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_ex_mem_rd (id_ex_mem_rd),
    .id_ex_rd     (id_ex_rd),
    .if_id_rs1    (if_id_rs1),
    .if_id_rs2    (if_id_rs2),
    .ex_br_taken  (ex_br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .ex_mem_en    (ex_mem_en),
    .if_id_flush  (if_id_flush),
    .id_ex_sel    (id_ex_sel),
    .mem_timeout  (mem_timeout)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Expected output bundle order: {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_sel}
  localparam logic [4:0] O_NORM   = 5'b11101;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_FLUSH  = 5'b11110;
  localparam logic [4:0] O_LDST   = 5'b00100;
  localparam logic [4:0] O_RST    = 5'b00000;

  typedef struct {
    logic       mem_rd;
    logic [4:0] rd, rs1, rs2;
    logic       br, req, rdy;
    logic [4:0] eo;
    logic       eto;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_sel};
  endfunction

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic br, input logic rq, input logic ry);
    id_ex_mem_rd = mr; id_ex_rd = rd; if_id_rs1 = r1; if_id_rs2 = r2;
    ex_br_taken = br; mem_req = rq; mem_ready = ry;
  endtask

  task automatic check_outs(input string name, input logic [4:0] eo, input logic eto);
    chk({name, "_en"}, 32'(outs()), 32'(eo));
    chk({name, "_to"}, 32'(mem_timeout), 32'(eto));
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with rst released.
  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Behavioural reference: pipeline actions from the priority rules plus a
  // little history (was the previous cycle a stall/flush, how long has memory
  // been waiting).
  bit          m_supp;
  int          m_wait;
  bit          m_to;
  int unsigned m_stall, m_flush;

  function automatic logic [4:0] model_out(input logic mr, input logic [4:0] rd,
      input logic [4:0] r1, input logic [4:0] r2, input logic br, input logic rq, input logic ry);
    bit lu;
    lu = mr && (rd != 0) && (rd == r1 || rd == r2);
    if (rq && !ry)        return O_FREEZE;
    else if (br)          return O_FLUSH;
    else if (lu && !m_supp) return O_LDST;
    else                  return O_NORM;
  endfunction

  task automatic model_step(input logic [4:0] eo, input logic rq, input logic ry);
    m_supp = (eo != O_NORM);
    if (rq && !ry) begin
      if (m_wait < T) m_wait++;
      if (m_wait == T) m_to = 1'b1;
    end else begin
      m_wait = 0;
    end
    if (eo[4] == 1'b0) m_stall++;
    if (eo[1] == 1'b1) m_flush++;
  endtask

  initial begin
    // Directed vectors, applied from RUN right after reset.
    tbl[0]  = '{1, 5, 0, 5, 0, 0, 0, O_LDST,   0}; // load-use on rs2
    tbl[1]  = '{1, 5, 0, 5, 0, 0, 0, O_NORM,   0}; // held: one bubble only
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, O_NORM,   0}; // rd = x0 never stalls
    tbl[3]  = '{1, 7, 7, 0, 1, 0, 0, O_FLUSH,  0}; // branch beats load-use
    tbl[4]  = '{1, 7, 7, 0, 0, 0, 0, O_NORM,   0}; // FLUSH suppresses load-use
    tbl[5]  = '{1, 7, 7, 0, 0, 0, 0, O_LDST,   0}; // back in RUN: stall
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, O_FREEZE, 0}; // mem stall from LDSTALL
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, O_FREEZE, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, O_FREEZE, 0}; // third wait cycle
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 1, O_NORM,   0}; // release, no timeout
    tbl[10] = '{0, 0, 0, 0, 1, 1, 0, O_FREEZE, 0}; // mem stall beats branch
    tbl[11] = '{0, 0, 0, 0, 1, 1, 1, O_FLUSH,  0}; // release with branch
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, O_NORM,   0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check_outs("reset", O_RST, 1'b0);
    @(posedge clk); #1;
    check_outs("reset_held", O_RST, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].mem_rd, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].br, tbl[i].req, tbl[i].rdy);
      #3;
      check_outs($sformatf("vec%0d", i), tbl[i].eo, tbl[i].eto);
      @(posedge clk); #1;
    end

    // Timeout: four wait edges set the flag, which then survives release.
    do_reset();
    for (int i = 0; i < T; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      #3;
      check_outs($sformatf("towait%0d", i), O_FREEZE, 1'b0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    #3;
    check_outs("to_set", O_FREEZE, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 1);
    #3;
    check_outs("to_release", O_NORM, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    check_outs("to_sticky", O_NORM, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a memory wait.
    drive(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_outs("async_rst", O_RST, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    check_outs("post_rst", O_NORM, 1'b0);
    @(posedge clk); #1;
    drive(1, 3, 3, 0, 0, 0, 0);
    #3;
    check_outs("post_rst_run", O_LDST, 1'b0);
    @(posedge clk); #1;

    // Randomized run against the reference model.
    do_reset();
    m_supp = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < 400; i++) begin
      logic       mr, br, rq, ry;
      logic [4:0] rd, r1, r2, eo;
      mr = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      br = ($urandom_range(0, 5) == 0);
      rq = ($urandom_range(0, 2) != 0);
      ry = (i < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      eo = model_out(mr, rd, r1, r2, br, rq, ry);
      drive(mr, rd, r1, r2, br, rq, ry);
      #3;
      check_outs($sformatf("rnd%0d", i), eo, m_to);
      @(posedge clk);
      model_step(eo, rq, ry);
      #1;
    end
`ifdef PIPE_STALL_PERF_EN
    chk("stall_cnt", stall_cnt, 32'(m_stall));
    chk("flush_cnt", flush_cnt, 32'(m_flush));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
